// File: rtl/jk_excite_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jk_excite_ctrl
//  Purpose  : Drives a bank of W synchronous JK flops. It takes one request
//             at a time (LOAD / CLEAR / SET / TOGGLE) and applies one cycle of
//             excitation. It then checks the Q feedback and retries with
//             minimal-change J/K until the bank matches or the retries run out.
//  Revision : 1.0  initial release
// ============================================================================
module jk_excite_ctrl #(
  parameter int W         = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic         Clk,
  input  logic         R,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [1:0]   req_op,
  input  logic [W-1:0] req_data,
  input  logic [W-1:0] q_fb,
  output logic [W-1:0] jk_j,
  output logic [W-1:0] jk_k,
  output logic         jk_ce,
  output logic         jk_r,
  output logic         jk_s,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_SET    = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] expected;
  logic [3:0]   retry_cnt;

  // Only IDLE can take a new request; this is the one unregistered output.
  assign req_ready = (state == IDLE);

  // Controller FSM. All drive and status outputs are registered here. Drive
  // outputs default to zero every cycle, so each excitation lasts exactly
  // the single DRIVE cycle.
  always_ff @(posedge Clk) begin
    if (R) begin
      state     <= IDLE;
      expected  <= '0;
      retry_cnt <= '0;
      jk_j      <= '0;
      jk_k      <= '0;
      jk_ce     <= 1'b0;
      jk_r      <= 1'b0;
      jk_s      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      jk_j  <= '0;
      jk_k  <= '0;
      jk_ce <= 1'b0;
      jk_r  <= 1'b0;
      jk_s  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            retry_cnt <= '0;
            busy      <= 1'b1;
            state     <= DRIVE;
            case (req_op)
              OP_LOAD: begin
                expected <= req_data;
                // Excite only the bits that must move.
                jk_j     <= ~q_fb & req_data;
                jk_k     <= q_fb & ~req_data;
                jk_ce    <= 1'b1;
              end
              OP_CLEAR: begin
                expected <= '0;
                jk_r     <= 1'b1;
              end
              OP_SET: begin
                expected <= '1;
                jk_s     <= 1'b1;
              end
              OP_TOGGLE: begin
                expected <= ~q_fb;
                jk_j     <= '1;
                jk_k     <= '1;
                jk_ce    <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        DRIVE: begin
          // The bank updates on the edge that ends this cycle.
          state <= CHECK;
        end
        CHECK: begin
          if (q_fb == expected) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (retry_cnt < RETRY_LIMIT) begin
            // A retry always steers toward the target with J/K. This holds
            // even for CLEAR/SET, because R/S failing again would not help.
            retry_cnt <= retry_cnt + 4'd1;
            jk_j      <= ~q_fb & expected;
            jk_k      <= q_fb & ~expected;
            jk_ce     <= 1'b1;
            state     <= DRIVE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jk_excite_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jk_excite_ctrl
//  Purpose  : Directed bench for jk_excite_ctrl driving a behavioural 4-bit JK
//             bank (R > S > CE priority) with per-bit stuck-at-0 injection.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jk_excite_ctrl;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         R = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [1:0]   req_op = 2'b00;
  logic [W-1:0] req_data = '0;
  logic [W-1:0] q_fb;
  logic [W-1:0] jk_j, jk_k;
  logic         jk_ce, jk_r, jk_s, busy, done, err;

  logic [W-1:0] bank = '0;
  logic [W-1:0] sa0 = '0;

  int total = 0;
  int bad = 0;

  jk_excite_ctrl #(.W(W), .MAX_RETRY(2)) dut (
    .Clk(Clk), .R(R), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .q_fb(q_fb),
    .jk_j(jk_j), .jk_k(jk_k), .jk_ce(jk_ce), .jk_r(jk_r), .jk_s(jk_s),
    .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  // Behavioural JK bank; stuck-at-0 bits never leave 0.
  function automatic logic [W-1:0] bank_next(input logic [W-1:0] q);
    if (jk_r)       return '0;
    else if (jk_s)  return '1;
    else if (jk_ce) return (jk_j & ~q) | (~jk_k & q);
    else            return q;
  endfunction

  always @(posedge Clk) bank <= bank_next(bank) & ~sa0;

  assign q_fb = bank;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one request. Check the first DRIVE cycle, the latency to done, err,
  // the number of drive cycles and the final bank value. The task returns in
  // the done cycle, so the next call is a back-to-back request.
  task automatic do_req(input string tag, input logic [1:0] op, input logic [3:0] data,
                        input logic [10:0] exp_drive, input int exp_lat, input logic exp_err,
                        input int exp_drives, input logic [3:0] exp_bank, input logic release_stuck);
    int lat;
    int drives;
    lat = 0;
    drives = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    tick();
    req_valid = 1'b0;
    req_data  = 4'hF;
    chk({tag, ".drive1"}, 32'({jk_j, jk_k, jk_ce, jk_r, jk_s}), 32'(exp_drive));
    if (jk_ce | jk_r | jk_s) drives++;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (k == 2 && release_stuck) sa0 = '0;
      if (jk_ce | jk_r | jk_s) drives++;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".err"}, 32'(err), 32'(exp_err));
    chk({tag, ".drives"}, 32'(drives), 32'(exp_drives));
    chk({tag, ".bank"}, 32'(q_fb), 32'(exp_bank));
    chk({tag, ".ready"}, 32'({req_ready, busy}), 32'(2'b10));
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("reset.outs", 32'({jk_j, jk_k, jk_ce, jk_r, jk_s, busy, done, err, req_ready}),
        32'(15'b0000_0000_000_000_1));
    R = 1'b0;
    tick();
    chk("idle.outs", 32'({jk_j, jk_k, jk_ce, jk_r, jk_s, busy, done, err, req_ready}),
        32'(15'b0000_0000_000_000_1));

    //      tag       op     data     {J,K,ce,r,s}           lat err drv bank  rel
    do_req("load1",   2'b00, 4'b1010, 11'b1010_0000_1_0_0,   3,  0,  1,  4'b1010, 0);
    do_req("load2",   2'b00, 4'b0110, 11'b0100_1000_1_0_0,   3,  0,  1,  4'b0110, 0);
    do_req("toggle",  2'b11, 4'b0000, 11'b1111_1111_1_0_0,   3,  0,  1,  4'b1001, 0);
    do_req("set",     2'b10, 4'b0000, 11'b0000_0000_0_0_1,   3,  0,  1,  4'b1111, 0);
    do_req("clear",   2'b01, 4'b1111, 11'b0000_0000_0_1_0,   3,  0,  1,  4'b0000, 0);
    tick();
    chk("done.pulse", 32'({done, err}), 32'(2'b00));

    // Permanent stuck-at-0 on bit0: two retries, then error.
    sa0 = 4'b0001;
    do_req("stuck",   2'b00, 4'b0001, 11'b0001_0000_1_0_0,   7,  1,  3,  4'b0000, 0);
    tick();
    // Stuck for the first attempt only: one retry succeeds.
    sa0 = 4'b0001;
    do_req("once",    2'b00, 4'b0001, 11'b0001_0000_1_0_0,   5,  0,  2,  4'b0001, 1);
    tick();

    // Reset while in DRIVE: everything drops, no done follows.
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_data  = 4'b1111;
    tick();
    req_valid = 1'b0;
    chk("rst.drive", 32'({jk_j, jk_k, jk_ce}), 32'(9'b1110_0000_1));
    R = 1'b1;
    tick();
    R = 1'b0;
    chk("rst.outs", 32'({jk_j, jk_k, jk_ce, jk_r, jk_s, busy, done, err, req_ready}),
        32'(15'b0000_0000_000_000_1));
    tick();
    tick();
    chk("rst.nodone", 32'({done, busy}), 32'(2'b00));

    // Bank is 1111 after the aborted drive; back-to-back pair.
    do_req("b2b1",    2'b00, 4'b0101, 11'b0000_1010_1_0_0,   3,  0,  1,  4'b0101, 0);
    do_req("b2b2",    2'b11, 4'b0000, 11'b1111_1111_1_0_0,   3,  0,  1,  4'b1010, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
